vrp_n2m_rr_arb: RTL and testbench

- Generalised N-request to M-grant arbiter for the vector request path, successor to the fixed 10-to-2 lead-one arbiter.
- Adds round-robin fairness through a rotating priority pointer, a configurable grant-port count M, and a registered per-port output slot with independent valid/ready handshake.
- Sits between the read/write request sources and the downstream channel/RAM issue logic; each accepted request lands in exactly one grant slot.

---
 rtl/vrp_n2m_rr_arb.sv | 88 ++++++++
 tb/tb_vrp_n2m_rr_arb.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/vrp_n2m_rr_arb.sv
// N-request to M-grant round-robin arbiter with a registered valid/ready output slot per grant port.
// Free slots are filled in ascending order, taking requesters in circular order from rr_ptr.
module vrp_n2m_rr_arb #(
  parameter int N         = 10,
  parameter int M         = 2,
  parameter int PLD_WIDTH = 8,
  localparam int IDX_W    = $clog2(N)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N-1:0]                      req_vld,
  output logic [N-1:0]                      req_rdy,
  input  logic [N-1:0][PLD_WIDTH-1:0]       req_pld,
  output logic [M-1:0]                      grant_vld,
  input  logic [M-1:0]                      grant_rdy,
  output logic [M-1:0][IDX_W-1:0]           grant_idx,
  output logic [M-1:0][PLD_WIDTH-1:0]       grant_pld
);

  logic [IDX_W-1:0]          rr_ptr;
  logic [IDX_W-1:0]          rr_nxt;
  logic [IDX_W-1:0]          last_idx;
  logic [IDX_W-1:0]          idx_c;
  logic [M-1:0]              avail;
  logic [M-1:0]              load;
  logic [M-1:0][IDX_W-1:0]   load_src;
  logic [N-1:0]              rdy_c;
  logic                      any_pair;
  logic                      taken;

  // The k-th valid requester in scan order lands in the k-th free slot.
  always_comb begin
    avail    = ~grant_vld | grant_rdy;
    load     = '0;
    load_src = '0;
    rdy_c    = '0;
    last_idx = '0;
    any_pair = 1'b0;
    idx_c    = '0;
    taken    = 1'b0;
    for (int j = 0; j < N; j++) begin
      idx_c = IDX_W'((int'(rr_ptr) + j) % N);
      taken = 1'b0;
      if (req_vld[idx_c]) begin
        for (int m = 0; m < M; m++) begin
          if (avail[m] && !taken) begin
            taken       = 1'b1;
            avail[m]    = 1'b0;
            load[m]     = 1'b1;
            load_src[m] = idx_c;
          end
        end
        if (taken) begin
          rdy_c[idx_c] = 1'b1;
          last_idx     = idx_c;
          any_pair     = 1'b1;
        end
      end
    end
  end

  assign rr_nxt  = (last_idx == IDX_W'(N - 1)) ? '0 : last_idx + 1'b1;
  // Reset gating: with all slots cleared every slot looks free, so acceptance must be masked.
  assign req_rdy = rdy_c & {N{rst_n}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_vld <= '0;
      grant_idx <= '0;
      grant_pld <= '0;
      rr_ptr    <= '0;
    end else begin
      for (int m = 0; m < M; m++) begin
        if (load[m]) begin
          grant_vld[m] <= 1'b1;
          grant_idx[m] <= load_src[m];
          grant_pld[m] <= req_pld[load_src[m]];
        end else if (grant_rdy[m]) begin
          grant_vld[m] <= 1'b0;
        end
      end
      if (any_pair) begin
        rr_ptr <= rr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_vrp_n2m_rr_arb.sv
// Directed bench for vrp_n2m_rr_arb (N=10, M=2): vector table plus hand-written
// sequences for reset, same-cycle drain/refill and asynchronous reset mid-burst.
module tb_vrp_n2m_rr_arb;

  localparam int N  = 10;
  localparam int M  = 2;
  localparam int PW = 8;
  localparam int IW = 4;

  logic                     clk;
  logic                     rst_n;
  logic [N-1:0]             req_vld;
  logic [N-1:0]             req_rdy;
  logic [N-1:0][PW-1:0]     req_pld;
  logic [M-1:0]             grant_vld;
  logic [M-1:0]             grant_rdy;
  logic [M-1:0][IW-1:0]     grant_idx;
  logic [M-1:0][PW-1:0]     grant_pld;

  int checks = 0;
  int errors = 0;

  vrp_n2m_rr_arb #(.N(N), .M(M), .PLD_WIDTH(PW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_vld   (req_vld),
    .req_rdy   (req_rdy),
    .req_pld   (req_pld),
    .grant_vld (grant_vld),
    .grant_rdy (grant_rdy),
    .grant_idx (grant_idx),
    .grant_pld (grant_pld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] vld;
    logic [M-1:0] rdy;
    logic [N-1:0] exp_rdy;
    logic [M-1:0] exp_gv;
    logic [IW-1:0] i0;
    logic [IW-1:0] i1;
    logic [IW-1:0] ptr;
  } vec_t;

  localparam int NV = 14;
  vec_t vec [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic set_default_pld();
    for (int i = 0; i < N; i++) req_pld[i] = PW'(8'hA0 + i);
  endtask

  initial begin
    // round-robin rotation from reset with everything valid
    vec[0]  = '{10'h3FF, 2'b11, 10'h003, 2'b11, 4'd0, 4'd1, 4'd2};
    vec[1]  = '{10'h3FF, 2'b11, 10'h00C, 2'b11, 4'd2, 4'd3, 4'd4};
    vec[2]  = '{10'h3FF, 2'b11, 10'h030, 2'b11, 4'd4, 4'd5, 4'd6};
    vec[3]  = '{10'h3FF, 2'b11, 10'h0C0, 2'b11, 4'd6, 4'd7, 4'd8};
    vec[4]  = '{10'h3FF, 2'b11, 10'h300, 2'b11, 4'd8, 4'd9, 4'd0};
    vec[5]  = '{10'h3FF, 2'b11, 10'h003, 2'b11, 4'd0, 4'd1, 4'd2};
    // load slots with 3 and 7, leaving rr_ptr at 8
    vec[6]  = '{10'h088, 2'b11, 10'h088, 2'b11, 4'd3, 4'd7, 4'd8};
    // full backpressure
    vec[7]  = '{10'h3FF, 2'b00, 10'h000, 2'b11, 4'd3, 4'd7, 4'd8};
    vec[8]  = '{10'h3FF, 2'b00, 10'h000, 2'b11, 4'd3, 4'd7, 4'd8};
    vec[9]  = '{10'h3FF, 2'b00, 10'h000, 2'b11, 4'd3, 4'd7, 4'd8};
    vec[10] = '{10'h3FF, 2'b00, 10'h000, 2'b11, 4'd3, 4'd7, 4'd8};
    vec[11] = '{10'h3FF, 2'b00, 10'h000, 2'b11, 4'd3, 4'd7, 4'd8};
    // partial drain: only slot1 free, req 9 wins, req 2 waits
    vec[12] = '{10'h204, 2'b10, 10'h200, 2'b11, 4'd3, 4'd9, 4'd0};
    // empty: both slots drain
    vec[13] = '{10'h000, 2'b11, 10'h000, 2'b00, 4'd3, 4'd9, 4'd0};

    rst_n     = 1'b0;
    req_vld   = '1;
    grant_rdy = 2'b11;
    set_default_pld();

    for (int c = 0; c < 3; c++) begin
      #1;
      chk("reset_req_rdy", 32'(req_rdy), 32'h0);
      chk("reset_grant_vld", 32'(grant_vld), 32'h0);
      @(posedge clk);
    end
    #1 rst_n = 1'b1;

    for (int v = 0; v < NV; v++) begin
      req_vld   = vec[v].vld;
      grant_rdy = vec[v].rdy;
      #1;
      chk($sformatf("v%0d_req_rdy", v), 32'(req_rdy), 32'(vec[v].exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_grant_vld", v), 32'(grant_vld), 32'(vec[v].exp_gv));
      if (vec[v].exp_gv[0]) begin
        chk($sformatf("v%0d_idx0", v), 32'(grant_idx[0]), 32'(vec[v].i0));
        chk($sformatf("v%0d_pld0", v), 32'(grant_pld[0]), 32'hA0 + 32'(vec[v].i0));
      end
      if (vec[v].exp_gv[1]) begin
        chk($sformatf("v%0d_idx1", v), 32'(grant_idx[1]), 32'(vec[v].i1));
        chk($sformatf("v%0d_pld1", v), 32'(grant_pld[1]), 32'hA0 + 32'(vec[v].i1));
      end
      chk($sformatf("v%0d_rr_ptr", v), 32'(dut.rr_ptr), 32'(vec[v].ptr));
    end

    // same-cycle drain/refill on slot0 with a changing payload from req 4
    req_vld   = 10'h010;
    grant_rdy = 2'b01;
    for (int c = 0; c < 6; c++) begin
      req_pld[4] = PW'(8'h40 + c);
      #1;
      chk("stream_req_rdy", 32'(req_rdy), 32'h010);
      @(posedge clk);
      #1;
      chk("stream_grant_vld", 32'(grant_vld), 32'h1);
      chk("stream_idx0", 32'(grant_idx[0]), 32'd4);
      chk("stream_pld0", 32'(grant_pld[0]), 32'h40 + 32'(c));
      chk("stream_rr_ptr", 32'(dut.rr_ptr), 32'd5);
    end
    set_default_pld();

    // fill both slots, stall, then reset between clock edges
    req_vld   = 10'h3FF;
    grant_rdy = 2'b11;
    @(posedge clk);
    #1;
    chk("burst_grant_vld", 32'(grant_vld), 32'h3);
    chk("burst_idx0", 32'(grant_idx[0]), 32'd5);
    chk("burst_idx1", 32'(grant_idx[1]), 32'd6);
    chk("burst_rr_ptr", 32'(dut.rr_ptr), 32'd7);
    grant_rdy = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_grant_vld", 32'(grant_vld), 32'h0);
    chk("async_rst_req_rdy", 32'(req_rdy), 32'h0);
    chk("async_rst_rr_ptr", 32'(dut.rr_ptr), 32'h0);
    @(posedge clk);
    #1;
    chk("async_rst_hold_vld", 32'(grant_vld), 32'h0);
    rst_n     = 1'b1;
    req_vld   = 10'h0A4;
    grant_rdy = 2'b11;
    #1;
    chk("post_rst_req_rdy", 32'(req_rdy), 32'h024);
    @(posedge clk);
    #1;
    chk("post_rst_grant_vld", 32'(grant_vld), 32'h3);
    chk("post_rst_idx0", 32'(grant_idx[0]), 32'd2);
    chk("post_rst_idx1", 32'(grant_idx[1]), 32'd5);
    chk("post_rst_pld1", 32'(grant_pld[1]), 32'hA5);
    chk("post_rst_rr_ptr", 32'(dut.rr_ptr), 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
